traffic_phase_timer: RTL and testbench



---
 rtl/traffic_pkg.sv | 35 +++
 rtl/tick_prescaler.sv | 48 ++++
 rtl/traffic_phase_timer.sv | 119 +++++++++++
 tb/tb_traffic_phase_timer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic light subsystem: phase-timer state
// encoding, default timing constants and the 3-bit lamp codes driven onto the
// controller's L1..L8 outputs.
// -----------------------------------------------------------------------------
package traffic_pkg;

   // Phase timer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // waiting for the first phase-entry pulse
      ST_RUN  = 2'd1,   // timing the current phase
      ST_DONE = 2'd2    // long interval reached, counters frozen
   } timer_state_e;

   // Default timing: 100 MHz board clock, 5 s short / 15 s long interval
   localparam int DEF_CLK_DIV = 100_000_000;
   localparam int DEF_T_SHORT = 5;
   localparam int DEF_T_LONG  = 15;

   // Lamp codes, one bit per lamp {red, yellow, green}
   typedef enum logic [2:0] {
      LT_OFF        = 3'b000,
      LT_GREEN      = 3'b001,
      LT_YELLOW     = 3'b010,
      LT_RED        = 3'b100,
      LT_RED_YELLOW = 3'b110
   } light_e;

   // Width of a counter that holds 0..div-1; a divide-by-1 still needs one bit
   function automatic int prescale_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-cycle tick every CLK_DIV enabled cycles.
//
// Ports:
//   clk   in  - rising-edge clock
//   reset in  - asynchronous, active-high reset
//   clr   in  - synchronous clear of the count (wins over en)
//   en    in  - count enable; count holds while low
//   tick  out - high in the enabled cycle where the count wraps to 0
// -----------------------------------------------------------------------------
module tick_prescaler
   import traffic_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            PW     = prescale_width(CLK_DIV);
   localparam logic [PW-1:0] C_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] r_cnt;
   logic          w_wrap;

   // Tick is combinational so the consumer's registered counter advances on
   // the same edge the prescaler wraps; with CLK_DIV=1 the count sits at 0
   // and every enabled cycle is a tick.
   assign w_wrap = (r_cnt == C_LAST);
   assign tick   = en && w_wrap;

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// traffic_phase_timer
// Times the current traffic phase in whole seconds and raises ts (short time
// elapsed) and then tl (long time elapsed) as levels held until the next
// start. hold freezes timing during an emergency override.
//
// Ports:
//   clk     in        - rising-edge clock
//   reset   in        - asynchronous, active-high reset
//   start   in        - one-cycle phase-entry pulse, (re)starts timing
//   hold    in        - level, freezes prescaler and seconds counter in RUN
//   ts      out       - registered, high once elapsed >= T_SHORT
//   tl      out       - registered, high once elapsed >= T_LONG
//   busy    out       - registered, high while timing a phase
//   elapsed out [CW]  - whole seconds elapsed in the current phase
// -----------------------------------------------------------------------------
module traffic_phase_timer
   import traffic_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int CW      = 8,
   parameter int T_SHORT = DEF_T_SHORT,
   parameter int T_LONG  = DEF_T_LONG
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          hold,
   output logic          ts,
   output logic          tl,
   output logic          busy,
   output logic [CW-1:0] elapsed
);

   localparam logic [CW-1:0] C_T_SHORT = CW'(T_SHORT);
   localparam logic [CW-1:0] C_T_LONG  = CW'(T_LONG);

   timer_state_e  r_state, w_state_next;
   logic [CW-1:0] r_elapsed, w_elapsed_next, w_elapsed_inc;
   logic          r_ts, w_ts_next;
   logic          r_tl, w_tl_next;
   logic          r_busy, w_busy_next;
   logic          w_pre_en, w_tick;

   // The prescaler only runs while timing and not frozen; start clears it and
   // takes priority over counting in the same cycle.
   assign w_pre_en = (r_state == ST_RUN) && !hold && !start;

   tick_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (start),
      .en    (w_pre_en),
      .tick  (w_tick)
   );

   assign w_elapsed_inc = r_elapsed + 1'b1;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      w_state_next   = r_state;
      w_elapsed_next = r_elapsed;
      w_ts_next      = r_ts;
      w_tl_next      = r_tl;

      if (start) begin
         w_state_next   = ST_RUN;
         w_elapsed_next = '0;
         w_ts_next      = 1'b0;
         w_tl_next      = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: ;
            ST_RUN: begin
               if (w_tick) begin
                  w_elapsed_next = w_elapsed_inc;
                  if (w_elapsed_inc == C_T_SHORT) w_ts_next = 1'b1;
                  // Reaching T_LONG saturates elapsed by leaving RUN
                  if (w_elapsed_inc == C_T_LONG) begin
                     w_tl_next    = 1'b1;
                     w_state_next = ST_DONE;
                  end
               end
            end
            ST_DONE: ;
            default: w_state_next = ST_IDLE;
         endcase
      end

      // busy is registered from the next state so it changes on the same
      // edge as the state itself
      w_busy_next = (w_state_next == ST_RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_elapsed <= '0;
         r_ts      <= 1'b0;
         r_tl      <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_elapsed <= w_elapsed_next;
         r_ts      <= w_ts_next;
         r_tl      <= w_tl_next;
         r_busy    <= w_busy_next;
      end
   end

   assign ts      = r_ts;
   assign tl      = r_tl;
   assign busy    = r_busy;
   assign elapsed = r_elapsed;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_timer
// Two instances: dut (CLK_DIV=4) and dut1 (CLK_DIV=1), both T_SHORT=3,
// T_LONG=6. Edge numbers are relative to the edge that samples start; a value
// "at edge E" is the one observed on the falling edge after rising edge E.
// Stimulus pushes expected {dut select, ts, tl, busy, elapsed} tagged with the
// absolute edge; the monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_traffic_phase_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0, hold = 1'b0;
   logic       start1 = 1'b0, hold1 = 1'b0;
   logic       ts, tl, busy, ts1, tl1, busy1;
   logic [7:0] elapsed, elapsed1;

   traffic_phase_timer #(
      .CLK_DIV (4), .CW (8), .T_SHORT (3), .T_LONG (6)
   ) dut (
      .clk (clk), .reset (reset), .start (start), .hold (hold),
      .ts (ts), .tl (tl), .busy (busy), .elapsed (elapsed)
   );

   traffic_phase_timer #(
      .CLK_DIV (1), .CW (8), .T_SHORT (3), .T_LONG (6)
   ) dut1 (
      .clk (clk), .reset (reset), .start (start1), .hold (hold1),
      .ts (ts1), .tl (tl1), .busy (busy1), .elapsed (elapsed1)
   );

   always #5 clk = ~clk;

   int cyc = 0;      // number of rising edges seen
   int base = 0;     // absolute edge number of the scenario's edge 0
   int checks = 0;
   int errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard queues (parallel)
   int          q_cyc[$];
   logic [11:0] q_val[$];
   string       q_name[$];

   task automatic expect_at(input int rel, input bit d1, input logic e_ts,
                            input logic e_tl, input logic e_busy,
                            input logic [7:0] e_el, input string name);
      q_cyc.push_back(base + rel);
      q_val.push_back({d1, e_ts, e_tl, e_busy, e_el});
      q_name.push_back(name);
   endtask

   task automatic wait_rel(input int r);
      while (cyc < base + r) @(negedge clk);
   endtask

   // Monitor
   int          m_c;
   logic [11:0] m_v, m_got;
   string       m_n;

   always @(negedge clk) begin
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
         m_c = q_cyc.pop_front();
         m_v = q_val.pop_front();
         m_n = q_name.pop_front();
         m_got = m_v[11] ? {1'b1, ts1, tl1, busy1, elapsed1}
                         : {1'b0, ts, tl, busy, elapsed};
         checks++;
         if (m_c != cyc) begin
            errors++;
            $display("FAIL %s: check for edge %0d reached late at edge %0d", m_n, m_c, cyc);
         end else if (m_got !== m_v) begin
            errors++;
            $display("FAIL %s @edge %0d: got ts=%b tl=%b busy=%b elapsed=%0d, expected ts=%b tl=%b busy=%b elapsed=%0d",
                     m_n, cyc, m_got[10], m_got[9], m_got[8], m_got[7:0],
                     m_v[10], m_v[9], m_v[8], m_v[7:0]);
         end
      end
   end

   // Starts a scenario: the next rising edge becomes edge 0 and samples start
   task automatic begin_scenario();
      @(negedge clk);
      base = cyc + 1;
   endtask

   initial begin
      // ---------------- reset values ----------------
      repeat (2) @(negedge clk);
      base = cyc + 1;
      expect_at(0, 1'b0, 0, 0, 0, 8'd0, "reset_dut");
      expect_at(0, 1'b1, 0, 0, 0, 8'd0, "reset_dut1");
      wait_rel(0);
      reset = 1'b0;

      // ---------------- S1: plain run, then hold in DONE ----------------
      begin_scenario();
      expect_at(1,  0, 0, 0, 1, 8'd0, "s1_start");
      expect_at(11, 0, 0, 0, 1, 8'd2, "s1_pre_ts");
      expect_at(12, 0, 1, 0, 1, 8'd3, "s1_ts_rise");
      expect_at(23, 0, 1, 0, 1, 8'd5, "s1_pre_tl");
      expect_at(24, 0, 1, 1, 0, 8'd6, "s1_tl_rise");
      expect_at(32, 0, 1, 1, 0, 8'd6, "s1_done_hold");
      expect_at(40, 0, 1, 1, 0, 8'd6, "s1_saturated");
      start = 1'b1;
      wait_rel(0);
      start = 1'b0;
      wait_rel(29); hold = 1'b1;
      wait_rel(35); hold = 1'b0;
      wait_rel(41);

      // ---------------- S2: restart at edge 16 ----------------
      begin_scenario();
      expect_at(1,  0, 0, 0, 1, 8'd0, "s2_start");
      expect_at(15, 0, 1, 0, 1, 8'd3, "s2_pre_restart");
      expect_at(16, 0, 0, 0, 1, 8'd0, "s2_restart");
      expect_at(17, 0, 0, 0, 1, 8'd0, "s2_after_restart");
      expect_at(20, 0, 0, 0, 1, 8'd1, "s2_first_sec");
      expect_at(27, 0, 0, 0, 1, 8'd2, "s2_pre_ts");
      expect_at(28, 0, 1, 0, 1, 8'd3, "s2_ts_rise");
      expect_at(39, 0, 1, 0, 1, 8'd5, "s2_pre_tl");
      expect_at(40, 0, 1, 1, 0, 8'd6, "s2_tl_rise");
      start = 1'b1;
      wait_rel(0);
      start = 1'b0;
      wait_rel(15); start = 1'b1;
      wait_rel(16); start = 1'b0;
      wait_rel(41);

      // ---------------- S3: hold on edges 5..14 ----------------
      begin_scenario();
      expect_at(4,  0, 0, 0, 1, 8'd1, "s3_pre_hold");
      expect_at(10, 0, 0, 0, 1, 8'd1, "s3_in_hold");
      expect_at(14, 0, 0, 0, 1, 8'd1, "s3_hold_end");
      expect_at(17, 0, 0, 0, 1, 8'd1, "s3_delayed_sec");
      expect_at(18, 0, 0, 0, 1, 8'd2, "s3_sec2");
      expect_at(21, 0, 0, 0, 1, 8'd2, "s3_pre_ts");
      expect_at(22, 0, 1, 0, 1, 8'd3, "s3_ts_rise");
      expect_at(33, 0, 1, 0, 1, 8'd5, "s3_pre_tl");
      expect_at(34, 0, 1, 1, 0, 8'd6, "s3_tl_rise");
      start = 1'b1;
      wait_rel(0);
      start = 1'b0;
      wait_rel(4);  hold = 1'b1;
      wait_rel(14); hold = 1'b0;
      wait_rel(35);

      // ---------------- S4: start with hold, hold drops after edge 5 -------
      begin_scenario();
      expect_at(1,  0, 0, 0, 1, 8'd0, "s4_busy");
      expect_at(8,  0, 0, 0, 1, 8'd0, "s4_still_zero");
      expect_at(9,  0, 0, 0, 1, 8'd1, "s4_first_sec");
      expect_at(16, 0, 0, 0, 1, 8'd2, "s4_pre_ts");
      expect_at(17, 0, 1, 0, 1, 8'd3, "s4_ts_rise");
      start = 1'b1;
      hold  = 1'b1;
      wait_rel(0);
      start = 1'b0;
      wait_rel(5);  hold = 1'b0;
      wait_rel(18);

      // ---------------- S5: async reset mid-run ----------------
      begin_scenario();
      expect_at(12, 0, 1, 0, 1, 8'd3, "s5_before_rst");
      expect_at(13, 0, 0, 0, 0, 8'd0, "s5_async_clear");
      for (int r = 16; r < 66; r++)
         expect_at(r, 0, 0, 0, 0, 8'd0, "s5_idle_after_rst");
      expect_at(81, 0, 0, 0, 1, 8'd2, "s5_pre_ts");
      expect_at(82, 0, 1, 0, 1, 8'd3, "s5_ts_rise");
      start = 1'b1;
      wait_rel(0);
      start = 1'b0;
      wait_rel(12);
      @(posedge clk);
      #2 reset = 1'b1;
      wait_rel(15); reset = 1'b0;
      wait_rel(69); start = 1'b1;
      wait_rel(70); start = 1'b0;
      wait_rel(83);

      // ---------------- S6: CLK_DIV = 1 ----------------
      begin_scenario();
      expect_at(0,  1, 0, 0, 1, 8'd0, "s6_start");
      expect_at(1,  1, 0, 0, 1, 8'd1, "s6_sec1");
      expect_at(2,  1, 0, 0, 1, 8'd2, "s6_pre_ts");
      expect_at(3,  1, 1, 0, 1, 8'd3, "s6_ts_rise");
      expect_at(5,  1, 1, 0, 1, 8'd5, "s6_pre_tl");
      expect_at(6,  1, 1, 1, 0, 8'd6, "s6_tl_rise");
      expect_at(10, 1, 1, 1, 0, 8'd6, "s6_saturated");
      start1 = 1'b1;
      wait_rel(0);
      start1 = 1'b0;
      wait_rel(12);

      repeat (2) @(negedge clk);
      if (q_cyc.size() != 0) begin
         checks += q_cyc.size();
         errors += q_cyc.size();
         $display("FAIL scoreboard_drain: %0d expected entries never checked", q_cyc.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100_000;
      $display("FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
      $fatal(1);
   end

endmodule
